// File: rtl/grayscale_pipe.sv
// Grayscale conversion stage between an input and an output pixel FIFO.
// Per-pixel mode (passthrough / mean / BT.601 luma), two pipeline stages, backpressure-safe.
module grayscale_pipe #(
    parameter int CHANNELS    = 3,
    parameter int CH_WIDTH    = 8,
    // Derived from the two above; keep at its default.
    parameter int FIFO_DWIDTH = CHANNELS * CH_WIDTH,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             mode,
    output logic                   fifo_in_rd_en,
    input  logic [FIFO_DWIDTH-1:0] fifo_in_dout,
    input  logic                   fifo_in_empty,
    output logic                   fifo_out_wr_en,
    output logic [FIFO_DWIDTH-1:0] fifo_out_din,
    input  logic                   fifo_out_full,
    output logic [COUNT_WIDTH-1:0] pixel_count
);

    localparam int AVG_W = CH_WIDTH + $clog2(CHANNELS) + 1;
    localparam int WT_W  = CH_WIDTH + 9;
    localparam int SUM_W = (AVG_W > WT_W) ? AVG_W : WT_W;

    localparam logic [1:0] KIND_PASS = 2'd0;
    localparam logic [1:0] KIND_AVG  = 2'd1;
    localparam logic [1:0] KIND_WT   = 2'd2;

    // Handshake: the input side is first-word-fall-through, a word is taken when
    // rd_en=1 (only while !empty); the output side accepts a word when wr_en=1
    // (only while !full). Both transfers complete on the same rising edge.
    logic                   advance;

    logic                   s1_valid_q, s1_valid_d;
    logic [1:0]             s1_kind_q, s1_kind_d;
    logic [FIFO_DWIDTH-1:0] s1_raw_q, s1_raw_d;
    logic [SUM_W-1:0]       s1_sum_q, s1_sum_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [FIFO_DWIDTH-1:0] dout_q, dout_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [SUM_W-1:0]       avg_sum;
    logic [SUM_W-1:0]       wt_sum;
    logic [1:0]             in_kind;
    logic [CH_WIDTH-1:0]    gray;

    always_comb begin
        avg_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            avg_sum = avg_sum + SUM_W'(fifo_in_dout[(CHANNELS-1-i)*CH_WIDTH +: CH_WIDTH]);
        end
    end

    // Weighted luma only exists for three channels; otherwise it degrades to the mean.
    if (CHANNELS == 3) begin : g_wt
        logic [CH_WIDTH-1:0] c0, c1, c2;
        assign c0 = fifo_in_dout[3*CH_WIDTH-1 -: CH_WIDTH];
        assign c1 = fifo_in_dout[2*CH_WIDTH-1 -: CH_WIDTH];
        assign c2 = fifo_in_dout[CH_WIDTH-1   -: CH_WIDTH];
        assign wt_sum = SUM_W'(77)  * SUM_W'(c0)
                      + SUM_W'(150) * SUM_W'(c1)
                      + SUM_W'(29)  * SUM_W'(c2)
                      + SUM_W'(128);
    end else begin : g_no_wt
        assign wt_sum = avg_sum;
    end

    always_comb begin
        if (mode == 2'd0) begin
            in_kind = KIND_PASS;
        end else if (mode == 2'd2 && CHANNELS == 3) begin
            in_kind = KIND_WT;
        end else begin
            in_kind = KIND_AVG;
        end
    end

    always_comb begin
        if (s1_kind_q == KIND_WT) begin
            gray = CH_WIDTH'(s1_sum_q >> 8);
        end else begin
            gray = CH_WIDTH'(s1_sum_q / SUM_W'(CHANNELS));
        end
    end

    // Handshake outputs; the write is suppressed in the reset cycle so in-flight data is discarded.
    always_comb begin
        advance        = !(s2_valid_q && fifo_out_full);
        fifo_in_rd_en  = !reset && !fifo_in_empty && advance;
        fifo_out_wr_en = !reset && s2_valid_q && !fifo_out_full;
        fifo_out_din   = dout_q;
        pixel_count    = count_q;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_kind_d  = s1_kind_q;
        s1_raw_d   = s1_raw_q;
        s1_sum_d   = s1_sum_q;
        s2_valid_d = s2_valid_q;
        dout_d     = dout_q;
        if (advance) begin
            s1_valid_d = fifo_in_rd_en;
            if (fifo_in_rd_en) begin
                s1_kind_d = in_kind;
                s1_raw_d  = fifo_in_dout;
                s1_sum_d  = (in_kind == KIND_WT) ? wt_sum : avg_sum;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = (s1_kind_q == KIND_PASS) ? s1_raw_q : {CHANNELS{gray}};
            end
        end
        count_d = fifo_out_wr_en ? count_q + COUNT_WIDTH'(1) : count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_kind_q  <= KIND_PASS;
            s1_raw_q   <= '0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            dout_q     <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_kind_q  <= s1_kind_d;
            s1_raw_q   <= s1_raw_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            dout_q     <= dout_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Bench for grayscale_pipe: directed vector table, mid-stream reset, counter wrap
// on a 4-bit-counter instance, and a randomised backpressure stream against a model.
module tb_grayscale_pipe;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] pix;
        logic [1:0]   mode;
        logic [W-1:0] exp;
    } vec_t;

    logic         clock;
    logic         reset;
    logic [1:0]   mode;
    logic         fifo_in_rd_en;
    logic [W-1:0] fifo_in_dout;
    logic         fifo_in_empty;
    logic         fifo_out_wr_en;
    logic [W-1:0] fifo_out_din;
    logic         fifo_out_full;
    logic [31:0]  pixel_count;

    logic         rd_en4;
    logic         wr_en4;
    logic [W-1:0] din4;
    logic [3:0]   count4;

    vec_t         in_q[$];
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    vec_t         tab[11];

    int checks;
    int failures;
    int cycle;
    int full_pct;
    int gap_pct;
    bit lat_chk;

    grayscale_pipe dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .fifo_in_rd_en (fifo_in_rd_en),
        .fifo_in_dout  (fifo_in_dout),
        .fifo_in_empty (fifo_in_empty),
        .fifo_out_wr_en(fifo_out_wr_en),
        .fifo_out_din  (fifo_out_din),
        .fifo_out_full (fifo_out_full),
        .pixel_count   (pixel_count)
    );

    grayscale_pipe #(.COUNT_WIDTH(4)) dut4 (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .fifo_in_rd_en (rd_en4),
        .fifo_in_dout  (fifo_in_dout),
        .fifo_in_empty (fifo_in_empty),
        .fifo_out_wr_en(wr_en4),
        .fifo_out_din  (din4),
        .fifo_out_full (fifo_out_full),
        .pixel_count   (count4)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] p, input logic [1:0] m);
        int c[3];
        int g;
        logic [7:0] gb;
        for (int i = 0; i < 3; i++) c[i] = int'(p[(2-i)*8 +: 8]);
        if (m == 2'd0) return p;
        if (m == 2'd2) g = (77*c[0] + 150*c[1] + 29*c[2] + 128) / 256;
        else g = (c[0] + c[1] + c[2]) / 3;
        gb = g[7:0];
        return {gb, gb, gb};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver: one clock per call, drives at negedge, samples 1 time unit later
    task automatic step(input bit rst);
        bit gap;
        vec_t v;
        logic [W-1:0] e;
        int c;
        @(negedge clock);
        reset = rst;
        fifo_out_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
        gap = (gap_pct > 0) && ($urandom_range(0, 99) < gap_pct);
        if (in_q.size() != 0 && !gap) begin
            fifo_in_empty = 1'b0;
            fifo_in_dout  = in_q[0].pix;
            mode          = in_q[0].mode;
        end else begin
            fifo_in_empty = 1'b1;
            fifo_in_dout  = W'($urandom);
            mode          = 2'($urandom_range(0, 3));
        end
        #1;
        cycle++;
        if (rst) begin
            check("rst_rd_en", fifo_in_rd_en, 0);
            check("rst_wr_en", fifo_out_wr_en, 0);
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            if (fifo_in_empty) check("rd_while_empty", fifo_in_rd_en, 0);
            if (fifo_out_full) check("wr_while_full", fifo_out_wr_en, 0);
            if (fifo_out_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fifo_out_din, 0 - 1);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("out_pixel", fifo_out_din, e);
                    if (wr_en4) check("out_pixel_w4", din4, e);
                    if (lat_chk) check("latency", cycle - c, 2);
                end
            end
            if (fifo_in_rd_en && !fifo_in_empty && in_q.size() != 0) begin
                v = in_q.pop_front();
                exp_q.push_back(v.exp);
                exp_cyc_q.push_back(cycle);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            step(0);
            n++;
        end
        if (in_q.size() != 0 || exp_q.size() != 0) check("drain_timeout", 1, 0);
        step(0);
    endtask

    task automatic push_random(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.pix  = W'($urandom);
            v.mode = 2'($urandom_range(0, 3));
            v.exp  = model(v.pix, v.mode);
            in_q.push_back(v);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cycle = 0;
        full_pct = 0; gap_pct = 0; lat_chk = 1'b1;
        reset = 1'b1; mode = 2'd0; fifo_in_dout = '0;
        fifo_in_empty = 1'b1; fifo_out_full = 1'b0;

        tab[0]  = '{24'h0A141E, 2'd1, 24'h141414};
        tab[1]  = '{24'hFFFFFE, 2'd1, 24'hFEFEFE};
        tab[2]  = '{24'hFF0000, 2'd2, 24'h4D4D4D};
        tab[3]  = '{24'h0A141E, 2'd2, 24'h121212};
        tab[4]  = '{24'hFFFFFF, 2'd2, 24'hFFFFFF};
        tab[5]  = '{24'h123456, 2'd0, 24'h123456};
        tab[6]  = '{24'h0A141E, 2'd1, 24'h141414};
        tab[7]  = '{24'h0A141E, 2'd3, 24'h141414};
        tab[8]  = '{24'h000000, 2'd2, 24'h000000};
        tab[9]  = '{24'h00FF00, 2'd2, 24'h959595};
        tab[10] = '{24'h0000FF, 2'd1, 24'h555555};

        // reset with a non-empty input FIFO, then the first pop right after release
        for (int i = 0; i < 11; i++) in_q.push_back(tab[i]);
        step(1);
        step(1);
        check("reset_count", pixel_count, 0);
        check("reset_count4", count4, 0);
        step(0);
        check("first_pop", fifo_in_rd_en, 1);
        check("first_wr_idle", fifo_out_wr_en, 0);
        drain();
        check("table_count", pixel_count, 11);

        // mid-stream reset discards the two pixels in flight
        step(1);
        push_random(4);
        step(0);
        step(0);
        step(1);
        check("midrst_remaining", in_q.size(), 2);
        drain();
        check("midrst_count", pixel_count, 2);
        check("midrst_count4", count4, 2);

        // counter wrap on the 4-bit instance
        step(1);
        push_random(17);
        drain();
        check("wrap_count4", count4, 1);
        check("wrap_count", pixel_count, 17);

        // random backpressure and input bubbles
        step(1);
        full_pct = 50;
        gap_pct  = 25;
        lat_chk  = 1'b0;
        push_random(100);
        drain();
        check("bp_count", pixel_count, 100);
        check("bp_count4", count4, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
